// File: rtl/matrix_scan_ctrl.sv
// Column-multiplexed refresh controller for a 5x7 dot-matrix display.
// A double-buffered frame store swaps into the active frame only at a column-0 entry.
module matrix_scan_ctrl #(
  parameter int unsigned DIV = 1000
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        enable,
  input  logic [34:0] frame_in,
  input  logic        frame_valid,
  output logic        frame_ready,
  output logic [4:0]  col_sel,
  output logic [6:0]  row_data,
  output logic        frame_start
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

  typedef enum logic [1:0] {IDLE, SCAN, BLANK} state_e;

  state_e        state_q, state_d;
  logic [2:0]    col_q, col_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [34:0]   active_q, active_d;
  logic [34:0]   pending_q, pending_d;
  logic          pending_full_q, pending_full_d;
  logic [4:0]    col_sel_q, col_sel_d;
  logic [6:0]    row_data_q, row_data_d;
  logic          frame_start_q, frame_start_d;
  logic          swap;
  logic          accept;

  always_comb begin
    state_d       = state_q;
    col_d         = col_q;
    cnt_d         = cnt_q;
    swap          = 1'b0;
    frame_start_d = 1'b0;
    if (!enable) begin
      state_d = IDLE;
      col_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d       = SCAN;
          col_d         = '0;
          cnt_d         = '0;
          swap          = pending_full_q;
          frame_start_d = 1'b1;
        end
        SCAN: begin
          if (cnt_q == CNT_MAX) begin
            state_d = BLANK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        BLANK: begin
          state_d = SCAN;
          cnt_d   = '0;
          if (col_q == 3'd4) begin
            col_d         = '0;
            swap          = pending_full_q;
            frame_start_d = 1'b1;
          end else begin
            col_d = col_q + 3'd1;
          end
        end
        default: begin
          state_d = IDLE;
          col_d   = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Accept is gated by the flag, so it can never coincide with a swap.
  always_comb begin
    accept         = frame_valid && !pending_full_q;
    active_d       = swap ? pending_q : active_q;
    pending_d      = accept ? frame_in : pending_q;
    pending_full_d = accept ? 1'b1 : (swap ? 1'b0 : pending_full_q);
  end

  // Outputs are registered from next-state values so they line up with state_q.
  always_comb begin
    col_sel_d  = '0;
    row_data_d = '0;
    if (state_d == SCAN) begin
      col_sel_d = 5'(1) << col_d;
      case (col_d)
        3'd0:    row_data_d = active_d[34:28];
        3'd1:    row_data_d = active_d[27:21];
        3'd2:    row_data_d = active_d[20:14];
        3'd3:    row_data_d = active_d[13:7];
        default: row_data_d = active_d[6:0];
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q        <= IDLE;
      col_q          <= '0;
      cnt_q          <= '0;
      active_q       <= '0;
      pending_q      <= '0;
      pending_full_q <= 1'b0;
      col_sel_q      <= '0;
      row_data_q     <= '0;
      frame_start_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      col_q          <= col_d;
      cnt_q          <= cnt_d;
      active_q       <= active_d;
      pending_q      <= pending_d;
      pending_full_q <= pending_full_d;
      col_sel_q      <= col_sel_d;
      row_data_q     <= row_data_d;
      frame_start_q  <= frame_start_d;
    end
  end

  assign frame_ready = !pending_full_q;
  assign col_sel     = col_sel_q;
  assign row_data    = row_data_q;
  assign frame_start = frame_start_q;

endmodule
